// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with an on-chip byte-addressed register file.
// Emulates a sensor register map so the I2C master can be brought up on-chip.
// Build option: define I2C_TGT_AUTOINC_EN to advance the register pointer after
// every data byte (burst access); when undefined the pointer holds.
module i2c_target_regfile #(
  parameter logic [6:0] TGT_ADDR    = 7'h53,
  parameter int         REG_AW      = 6,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              loc_we,
  input  logic [REG_AW-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic [7:0]        loc_rdata,
  output logic              bus_wr_valid,
  output logic [REG_AW-1:0] bus_wr_addr,
  output logic [7:0]        bus_wr_data,
  output logic              busy
);

`ifdef I2C_TGT_AUTOINC_EN
  localparam logic [REG_AW-1:0] PTR_STEP = REG_AW'(1);
`else
  localparam logic [REG_AW-1:0] PTR_STEP = '0;
`endif

  // fewer than two stages would not protect against metastability
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t            state;
  logic [NS-1:0]     scl_sync;
  logic [NS-1:0]     sda_sync;
  logic              scl_d;
  logic              sda_d;
  logic [7:0]        mem [2**REG_AW];
  logic [REG_AW-1:0] ptr;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic              ack_ph;
  logic              rd_mode;

  logic              scl_s;
  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  logic              bus_we;
  logic [7:0]        rx_byte;

  assign scl_s     = scl_sync[NS-1];
  assign sda_s     = sda_sync[NS-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign rx_byte   = {shreg[6:0], sda_s};
  assign bus_we    = !reset && !start_det && !stop_det && (state == WDATA)
                     && scl_rise && (bit_cnt == 3'd7);

  // Synchronize the bus lines; reset to idle-high so no false edge is seen
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[NS-2:0], scl_in};
      sda_sync <= {sda_sync[NS-2:0], sda_in};
      scl_d    <= scl_sync[NS-1];
      sda_d    <= sda_sync[NS-1];
    end
  end

  // Register file (kept through reset); a bus write beats a local write to the same index
  always_ff @(posedge CLOCK_50) begin
    if (loc_we && !(bus_we && (loc_addr == ptr)))
      mem[loc_addr] <= loc_wdata;
    if (bus_we)
      mem[ptr] <= rx_byte;
    loc_rdata <= mem[loc_addr];
  end

  // Protocol FSM: START/STOP override any state, bits sampled on SCL rise, SDA changed on SCL fall
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= IDLE;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      ptr          <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      ack_ph       <= 1'b0;
      rd_mode      <= 1'b0;
      bus_wr_valid <= 1'b0;
      bus_wr_addr  <= '0;
      bus_wr_data  <= '0;
    end else begin
      bus_wr_valid <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        ack_ph  <= 1'b0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        ack_ph <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE, IGNORE: begin
          end
          ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == TGT_ADDR) begin
                busy    <= 1'b1;
                rd_mode <= rx_byte[0];
                ack_ph  <= 1'b0;
                state   <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              ack_ph <= 1'b0;
              if (rd_mode) begin
                shreg  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= REG;
              end
            end
          end
          REG: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr    <= rx_byte[REG_AW-1:0];
              ack_ph <= 1'b0;
              state  <= REG_ACK;
            end
          end
          REG_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              ack_ph <= 1'b0;
              state  <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              bus_wr_valid <= 1'b1;
              bus_wr_addr  <= ptr;
              bus_wr_data  <= rx_byte;
              ack_ph       <= 1'b0;
              state        <= WDATA_ACK;
            end
          end
          WDATA_ACK: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1;
              ack_ph <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              ack_ph <= 1'b0;
              ptr    <= ptr + PTR_STEP;
              state  <= WDATA;
            end
          end
          RDATA: if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              ack_ph  <= 1'b0;
              state   <= RDATA_ACK;
            end else begin
              shreg   <= {shreg[6:0], 1'b0};
              sda_oe  <= ~shreg[6];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          RDATA_ACK: begin
            if (!ack_ph && scl_rise) begin
              if (sda_s) begin
                state <= IGNORE;
              end else begin
                ack_ph <= 1'b1;
                ptr    <= ptr + PTR_STEP;
              end
            end else if (ack_ph && scl_fall) begin
              ack_ph <= 1'b0;
              shreg  <= mem[ptr];
              sda_oe <= ~mem[ptr][7];
              state  <= RDATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
